// File: rtl/seg7_pkg.sv
// Shared constants and segment table for the 4-digit 7-segment scan driver.
// Patterns are active-low, bit order {g,f,e,d,c,b,a}.
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK  = 7'h7F;
    localparam logic [6:0] SEG_DASH   = 7'h3F;
    localparam logic [3:0] CODE_DASH  = 4'hA;
    localparam logic [3:0] CODE_BLANK = 4'hB;

    function automatic logic [6:0] seg_digit(input logic [3:0] d);
        logic [6:0] p;
        case (d)
            4'd0:    p = 7'h40;
            4'd1:    p = 7'h79;
            4'd2:    p = 7'h24;
            4'd3:    p = 7'h30;
            4'd4:    p = 7'h19;
            4'd5:    p = 7'h12;
            4'd6:    p = 7'h02;
            4'd7:    p = 7'h78;
            4'd8:    p = 7'h00;
            4'd9:    p = 7'h10;
            default: p = SEG_BLANK;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Digit-load and display-output bundle between the BCD source and the scan driver.
interface seg7_scan_driver_if;

    logic       load;
    logic [3:0] thousands;
    logic [3:0] hundreds;
    logic [3:0] tens;
    logic [3:0] ones;
    logic       lz_en;
    logic [3:0] an;
    logic [6:0] seg;
    logic       frame_tick;

    modport master (
        output load, thousands, hundreds, tens, ones, lz_en,
        input  an, seg, frame_tick
    );

    modport slave (
        input  load, thousands, hundreds, tens, ones, lz_en,
        output an, seg, frame_tick
    );

endinterface

// File: rtl/seg7_decoder.sv
// Combinational 4-bit digit code to active-low 7-segment pattern.
module seg7_decoder
    import seg7_pkg::*;
(
    input  logic [3:0] code,
    output logic [6:0] seg
);

    // Digits from the table, 10 is a dash, everything else is dark.
    always_comb begin
        seg = SEG_BLANK;
        if (code <= 4'd9) begin
            seg = seg_digit(code);
        end else if (code == CODE_DASH) begin
            seg = SEG_DASH;
        end else begin
            seg = SEG_BLANK;
        end
    end

endmodule

// File: rtl/seg7_scan_driver_chk.sv
// Simulation-time guard on the scan timing parameters.
module seg7_scan_driver_chk #(
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input logic clock
);

    // Slot length must allow at least one lit cycle after the dead-time gap.
    always @(posedge clock) begin
        assert (SCAN_DIV >= 2 && BLANK_CYCLES >= 0 && BLANK_CYCLES < SCAN_DIV)
        else $error("seg7_scan_driver: unsupported SCAN_DIV=%0d BLANK_CYCLES=%0d",
                    SCAN_DIV, BLANK_CYCLES);
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 4-digit common-anode 7-segment driver with frame-aligned
// digit capture, leading-zero blanking and per-slot dead time.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input logic               clock,
    input logic               reset,
    seg7_scan_driver_if.slave bus
);

    localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST  = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0] PRE_BLANK = PW'(BLANK_CYCLES);

    logic [PW-1:0]   prescaler_r;
    logic [1:0]      idx_r;
    logic [3:0][3:0] shadow_r;
    logic [3:0][3:0] disp_r;
    logic            shadow_lz_r;
    logic            disp_lz_r;
    logic [3:0]      an_r;
    logic [6:0]      seg_r;
    logic            frame_tick_r;

    logic            wrap_s;
    logic            boundary_s;
    logic [3:0][3:0] in_digits_s;
    logic            blank3_s;
    logic            blank2_s;
    logic            blank1_s;
    logic [3:0]      digit_s;
    logic [6:0]      seg_dec_s;

    assign wrap_s      = (prescaler_r == PRE_LAST);
    assign boundary_s  = wrap_s && (idx_r == 2'd3);
    assign in_digits_s = {bus.thousands, bus.hundreds, bus.tens, bus.ones};

    // Blanking chain: a digit goes dark only if every digit above it is dark.
    always_comb begin
        blank3_s = disp_lz_r && (disp_r[3] == 4'h0);
        blank2_s = blank3_s && (disp_r[2] == 4'h0);
        blank1_s = blank2_s && (disp_r[1] == 4'h0);
    end

    // Select the effective code for the digit currently being scanned.
    always_comb begin
        digit_s = CODE_BLANK;
        case (idx_r)
            2'd0:    digit_s = disp_r[0];
            2'd1:    digit_s = blank1_s ? CODE_BLANK : disp_r[1];
            2'd2:    digit_s = blank2_s ? CODE_BLANK : disp_r[2];
            2'd3:    digit_s = blank3_s ? CODE_BLANK : disp_r[3];
            default: digit_s = CODE_BLANK;
        endcase
    end

    seg7_decoder u_dec (
        .code (digit_s),
        .seg  (seg_dec_s)
    );

    seg7_scan_driver_chk #(
        .SCAN_DIV     (SCAN_DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_chk (
        .clock (clock)
    );

    // Scan counters and double-buffered digit capture.
    always_ff @(posedge clock) begin
        if (reset) begin
            prescaler_r <= '0;
            idx_r       <= 2'd0;
            shadow_r    <= {4{CODE_BLANK}};
            disp_r      <= {4{CODE_BLANK}};
            shadow_lz_r <= 1'b0;
            disp_lz_r   <= 1'b0;
        end else begin
            if (wrap_s) begin
                prescaler_r <= '0;
                idx_r       <= idx_r + 2'd1;
            end else begin
                prescaler_r <= prescaler_r + PW'(1);
            end
            if (bus.load) begin
                shadow_r    <= in_digits_s;
                shadow_lz_r <= bus.lz_en;
            end
            // A load landing on the boundary itself must not wait a whole frame.
            if (boundary_s) begin
                if (bus.load) begin
                    disp_r    <= in_digits_s;
                    disp_lz_r <= bus.lz_en;
                end else begin
                    disp_r    <= shadow_r;
                    disp_lz_r <= shadow_lz_r;
                end
            end
        end
    end

    // Registered display outputs, dark during the dead-time gap of each slot.
    always_ff @(posedge clock) begin
        if (reset) begin
            an_r         <= 4'b1111;
            seg_r        <= SEG_BLANK;
            frame_tick_r <= 1'b0;
        end else begin
            frame_tick_r <= boundary_s;
            if (prescaler_r < PRE_BLANK) begin
                an_r  <= 4'b1111;
                seg_r <= SEG_BLANK;
            end else begin
                an_r  <= ~(4'b0001 << idx_r);
                seg_r <= seg_dec_s;
            end
        end
    end

    assign bus.an         = an_r;
    assign bus.seg        = seg_r;
    assign bus.frame_tick = frame_tick_r;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed self-checking bench for seg7_scan_driver with SCAN_DIV=8, BLANK_CYCLES=2.
module tb_seg7_scan_driver;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    logic [6:0] exp_seg [4];
    localparam logic [3:0] AN_SLOT [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    seg7_scan_driver_if bus();

    seg7_scan_driver #(
        .SCAN_DIV     (8),
        .BLANK_CYCLES (2)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic drive(input logic ld, input logic [15:0] v, input logic lz);
        bus.load      = ld;
        bus.thousands = v[15:12];
        bus.hundreds  = v[11:8];
        bus.tens      = v[7:4];
        bus.ones      = v[3:0];
        bus.lz_en     = lz;
    endtask

    task automatic check3(input string tag, input logic [3:0] an_e,
                          input logic [6:0] seg_e, input logic ft_e);
        checks++;
        assert (bus.an === an_e) else begin
            errors++;
            $error("FAIL %s an observed=%b expected=%b", tag, bus.an, an_e);
        end
        checks++;
        assert (bus.seg === seg_e) else begin
            errors++;
            $error("FAIL %s seg observed=%h expected=%h", tag, bus.seg, seg_e);
        end
        checks++;
        assert (bus.frame_tick === ft_e) else begin
            errors++;
            $error("FAIL %s frame_tick observed=%b expected=%b", tag, bus.frame_tick, ft_e);
        end
    endtask

    // Steps through scan states k=0..last_k of one frame (8 cycles per slot),
    // optionally pulsing load while the scan is in state load_at.
    task automatic run_frame(input string tag, input int load_at,
                             input logic [15:0] ld_val, input logic ld_lz, input int last_k);
        int slot;
        int cyc;
        logic [3:0] an_e;
        logic [6:0] seg_e;
        for (int k = 0; k <= last_k; k++) begin
            drive(k == load_at, ld_val, ld_lz);
            @(posedge clock);
            @(negedge clock);
            slot  = k / 8;
            cyc   = k % 8;
            an_e  = (cyc < 2) ? 4'b1111 : AN_SLOT[slot];
            seg_e = (cyc < 2) ? 7'h7F : exp_seg[slot];
            check3($sformatf("%s k%0d", tag, k), an_e, seg_e, k == 31);
        end
        drive(1'b0, ld_val, ld_lz);
    endtask

    initial begin
        drive(1'b0, 16'hBBBB, 1'b0);
        reset = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check3("reset", 4'b1111, 7'h7F, 1'b0);
        reset = 1'b0;

        exp_seg = '{7'h7F, 7'h7F, 7'h7F, 7'h7F};
        run_frame("f1_blank", -1, 16'h0000, 1'b0, 31);
        run_frame("f2_blank", 5, 16'h1234, 1'b0, 31);

        exp_seg = '{7'h19, 7'h30, 7'h24, 7'h79};
        run_frame("f3_1234", 10, 16'h0050, 1'b1, 31);

        exp_seg = '{7'h40, 7'h12, 7'h7F, 7'h7F};
        run_frame("f4_lz0050", 20, 16'h0000, 1'b1, 31);

        exp_seg = '{7'h40, 7'h7F, 7'h7F, 7'h7F};
        run_frame("f5_lz0000", 3, 16'hA007, 1'b1, 31);

        exp_seg = '{7'h78, 7'h40, 7'h40, 7'h3F};
        run_frame("f6_dash", 12, 16'h9999, 1'b0, 31);

        exp_seg = '{7'h10, 7'h10, 7'h10, 7'h10};
        run_frame("f7_9999", 31, 16'h4321, 1'b0, 31);

        exp_seg = '{7'h79, 7'h24, 7'h30, 7'h19};
        run_frame("f8_bypass", 12, 16'h5555, 1'b0, 19);

        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check3("mid_reset0", 4'b1111, 7'h7F, 1'b0);
        @(posedge clock);
        @(negedge clock);
        check3("mid_reset1", 4'b1111, 7'h7F, 1'b0);
        reset = 1'b0;

        exp_seg = '{7'h7F, 7'h7F, 7'h7F, 7'h7F};
        run_frame("f9_after_reset", -1, 16'h0000, 1'b0, 31);
        run_frame("f10_shadow_gone", 4, 16'h0007, 1'b0, 31);

        exp_seg = '{7'h78, 7'h40, 7'h40, 7'h40};
        run_frame("f11_nolz0007", -1, 16'h0000, 1'b0, 31);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
